mem_arbiter: RTL

Two-to-one arbiter that shares one memory-side request port between the instruction-fetch (imem) and load/store (dmem) requesters of the core. It sits between the core's two bus masters and a single memory controller port. Transactions are one at a time, granted round-robin, with read/write response channels routed back to the granted requester. No requester sees a stall other than ready/valid back-pressure.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_e;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie, the port that was not served last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       grant_valid
);

  // Pick a port from the current requests and the last-served index.
  always_comb begin
    grant_valid = |req;
    grant       = PORT_IMEM;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[PORT_DMEM]) begin
      grant = PORT_DMEM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between imem and dmem, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_ADDR_BITS = 32,
  parameter int unsigned p_DATA_BITS = 32,
  parameter int unsigned p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  // imem requester
  input  logic [p_ADDR_BITS-1:0] imem_addr,
  input  logic                   imem_cmd,
  input  logic [1:0]             imem_size,
  input  logic                   imem_valid,
  output logic                   imem_ready,
  output logic                   imem_r_valid,
  output logic [p_DATA_BITS-1:0] imem_r_data,
  output logic                   imem_r_resp,
  input  logic                   imem_r_ready,
  // dmem requester
  input  logic [p_ADDR_BITS-1:0] dmem_addr,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_size,
  input  logic                   dmem_valid,
  output logic                   dmem_ready,
  output logic                   dmem_r_valid,
  output logic [p_DATA_BITS-1:0] dmem_r_data,
  output logic                   dmem_r_resp,
  input  logic                   dmem_r_ready,
  input  logic                   dmem_w_valid,
  input  logic [p_STRB_BITS-1:0] dmem_w_strb,
  input  logic [p_DATA_BITS-1:0] dmem_w_data,
  output logic                   dmem_w_ready,
  output logic                   dmem_w_resp,
  // downstream memory port
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_cmd,
  output logic [1:0]             mem_size,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  input  logic                   mem_r_valid,
  input  logic [p_DATA_BITS-1:0] mem_r_data,
  input  logic                   mem_r_resp,
  output logic                   mem_r_ready,
  output logic                   mem_w_valid,
  output logic [p_STRB_BITS-1:0] mem_w_strb,
  output logic [p_DATA_BITS-1:0] mem_w_data,
  input  logic                   mem_w_ready,
  input  logic                   mem_w_resp
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       r_last_q, r_last_d;

  logic       rr_grant;
  logic       rr_valid;

  logic [p_ADDR_BITS-1:0] g_addr;
  logic                   g_cmd;
  logic [1:0]             g_size;
  logic                   g_r_ready;

  mem_arb_rr u_rr (
    .req         ({dmem_valid, imem_valid}),
    .last        (r_last_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Select the granted requester's payload; payload is never registered.
  always_comb begin
    g_addr    = (grant_q == PORT_DMEM) ? dmem_addr    : imem_addr;
    g_cmd     = (grant_q == PORT_DMEM) ? dmem_cmd     : imem_cmd;
    g_size    = (grant_q == PORT_DMEM) ? dmem_size    : imem_size;
    g_r_ready = (grant_q == PORT_DMEM) ? dmem_r_ready : imem_r_ready;
  end

  // Output routing and next-state; every output idles at zero.
  always_comb begin
    mem_addr     = '0;
    mem_cmd      = 1'b0;
    mem_size     = '0;
    mem_valid    = 1'b0;
    mem_r_ready  = 1'b0;
    mem_w_valid  = 1'b0;
    mem_w_strb   = '0;
    mem_w_data   = '0;
    imem_ready   = 1'b0;
    imem_r_valid = 1'b0;
    imem_r_data  = '0;
    imem_r_resp  = 1'b0;
    dmem_ready   = 1'b0;
    dmem_r_valid = 1'b0;
    dmem_r_data  = '0;
    dmem_r_resp  = 1'b0;
    dmem_w_ready = 1'b0;
    dmem_w_resp  = 1'b0;
    state_d      = state_q;
    grant_d      = grant_q;
    r_last_d     = r_last_q;

    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          state_d = CMD;
        end
      end

      CMD: begin
        mem_valid = 1'b1;
        mem_addr  = g_addr;
        mem_cmd   = g_cmd;
        mem_size  = g_size;
        if (grant_q == PORT_DMEM) begin
          dmem_ready = mem_ready;
          // Only a write command opens the W channel, so a read can't consume write data.
          if (g_cmd == CMD_WRITE) begin
            mem_w_valid  = dmem_w_valid;
            mem_w_strb   = dmem_w_strb;
            mem_w_data   = dmem_w_data;
            dmem_w_ready = mem_w_ready;
            dmem_w_resp  = mem_w_resp;
          end
        end else begin
          imem_ready = mem_ready;
        end
        if (mem_ready) begin
          r_last_d = grant_q;
          if (g_cmd == CMD_READ) begin
            state_d = RDATA;
          end else if (mem_w_valid && mem_w_ready) begin
            state_d = IDLE;
          end else begin
            // An imem write never gets write data and parks here until reset.
            state_d = WDATA;
          end
        end
      end

      WDATA: begin
        if (grant_q == PORT_DMEM) begin
          mem_w_valid  = dmem_w_valid;
          mem_w_strb   = dmem_w_strb;
          mem_w_data   = dmem_w_data;
          dmem_w_ready = mem_w_ready;
          dmem_w_resp  = mem_w_resp;
        end
        if (mem_w_valid && mem_w_ready) begin
          state_d = IDLE;
        end
      end

      RDATA: begin
        mem_r_ready = g_r_ready;
        if (grant_q == PORT_DMEM) begin
          dmem_r_valid = mem_r_valid;
          dmem_r_data  = mem_r_data;
          dmem_r_resp  = mem_r_resp;
        end else begin
          imem_r_valid = mem_r_valid;
          imem_r_data  = mem_r_data;
          imem_r_resp  = mem_r_resp;
        end
        if (mem_r_valid && mem_r_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, grant and last-served registers; r_last starts at dmem so imem wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= PORT_IMEM;
      r_last_q <= PORT_DMEM;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      r_last_q <= r_last_d;
    end
  end

endmodule
